// File: rtl/cache_cmd_sequencer.sv
// cache_cmd_sequencer: buffers trace commands and issues them one at a time to the cache
module cache_cmd_sequencer #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 100
) (
    input  logic        clk,
    input  logic        rstb,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_n,
    input  logic [31:0] req_address,
    output logic        cache_valid,
    output logic [3:0]  cache_n,
    output logic [31:0] cache_address,
    input  logic        cache_done,
    output logic        print_pulse,
    output logic        busy,
    output logic [15:0] issued_cnt,
    output logic [15:0] timeout_cnt,
    output logic [15:0] bad_cmd_cnt,
    output logic        timeout_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int WW = $clog2(TIMEOUT + 1);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t        state, state_nx;
    logic [35:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic [WW-1:0] wait_cnt;
    logic [3:0]    head_n;
    logic [31:0]   head_addr;
    logic          push, pop, issue, is_op, is_clr, is_prt, is_bad, timeout_hit;

    assign req_ready   = count != (AW + 1)'(DEPTH);
    assign push        = req_valid && req_ready;
    assign pop         = (state == IDLE) && (count != '0);
    assign {head_n, head_addr} = mem[rd_ptr];
    assign is_op       = head_n <= 4'd6;
    assign is_clr      = head_n == 4'd8;
    assign is_prt      = head_n == 4'd9;
    assign is_bad      = !is_op && !is_clr && !is_prt;
    assign issue       = pop && (is_op || is_clr);
    assign timeout_hit = (state == WAIT) && !cache_done && (wait_cnt == WW'(TIMEOUT - 1));
    assign busy        = (state != IDLE) || (count != '0);

    // command storage; contents need no reset since count gates every read
    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= {req_n, req_address};

    // FIFO pointers and occupancy; simultaneous push and pop leave count unchanged
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW + 1)'(push) - (AW + 1)'(pop);
        end
    end

    // state register
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) state <= IDLE;
        else state <= state_nx;
    end

    // next state: only cache-bound commands leave IDLE; done beats a coincident timeout
    always_comb begin
        state_nx = state;
        if (state == IDLE) state_nx = issue ? WAIT : IDLE;
        else if (cache_done || timeout_hit) state_nx = IDLE;
    end

    // cache strobe, held command fields, wait timer and saturating statistics
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            cache_valid   <= 1'b0;
            cache_n       <= '0;
            cache_address <= '0;
            print_pulse   <= 1'b0;
            wait_cnt      <= '0;
            issued_cnt    <= '0;
            timeout_cnt   <= '0;
            bad_cmd_cnt   <= '0;
            timeout_err   <= 1'b0;
        end else begin
            cache_valid <= issue;
            print_pulse <= pop && is_prt;
            if (issue) begin
                cache_n       <= head_n;
                cache_address <= head_addr;
            end
            if (issue) wait_cnt <= '0;
            else if (state == WAIT) wait_cnt <= wait_cnt + WW'(1);
            if (pop && is_clr) begin
                issued_cnt  <= '0;
                bad_cmd_cnt <= '0;
            end else begin
                if (pop && is_op && issued_cnt != '1) issued_cnt <= issued_cnt + 16'd1;
                if (pop && is_bad && bad_cmd_cnt != '1) bad_cmd_cnt <= bad_cmd_cnt + 16'd1;
            end
            if (timeout_hit) begin
                timeout_err <= 1'b1;
                if (timeout_cnt != '1) timeout_cnt <= timeout_cnt + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_cache_cmd_sequencer.sv
// tb_cache_cmd_sequencer: directed self-checking bench for cache_cmd_sequencer
module tb_cache_cmd_sequencer;
    logic        clk = 1'b0;
    logic        rstb = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [3:0]  req_n = '0;
    logic [31:0] req_address = '0;
    logic        cache_valid;
    logic [3:0]  cache_n;
    logic [31:0] cache_address;
    logic        cache_done = 1'b0;
    logic        print_pulse;
    logic        busy;
    logic [15:0] issued_cnt, timeout_cnt, bad_cmd_cnt;
    logic        timeout_err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int push_cyc = 0;
    int done_delay = -1;
    int dcnt = -1;
    int prt_cnt = 0;
    logic [3:0]  iss_n[$];
    logic [31:0] iss_a[$];
    int          iss_c[$];

    cache_cmd_sequencer #(.DEPTH(4), .TIMEOUT(100)) dut (
        .clk(clk), .rstb(rstb), .req_valid(req_valid), .req_ready(req_ready),
        .req_n(req_n), .req_address(req_address), .cache_valid(cache_valid),
        .cache_n(cache_n), .cache_address(cache_address), .cache_done(cache_done),
        .print_pulse(print_pulse), .busy(busy), .issued_cnt(issued_cnt),
        .timeout_cnt(timeout_cnt), .bad_cmd_cnt(bad_cmd_cnt), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // cache responder and observer: logs strobes, answers done_delay cycles after each strobe
    always @(negedge clk or negedge rstb) begin
        if (!rstb) begin
            cache_done = 1'b0;
            dcnt = -1;
        end else begin
            cache_done = 1'b0;
            if (cache_valid) begin
                dcnt = 0;
                iss_n.push_back(cache_n);
                iss_a.push_back(cache_address);
                iss_c.push_back(cyc);
            end else if (dcnt >= 0) dcnt++;
            if (dcnt >= 0 && dcnt == done_delay) begin
                cache_done = 1'b1;
                dcnt = -1;
            end
            if (print_pulse) prt_cnt++;
        end
    end

    task automatic clear_log();
        iss_n.delete();
        iss_a.delete();
        iss_c.delete();
        prt_cnt = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        req_valid = 1'b0;
        done_delay = -1;
        rstb = 1'b0;
        @(negedge clk);
        rstb = 1'b1;
        clear_log();
    endtask

    task automatic push(input logic [3:0] n, input logic [31:0] a);
        int k = 0;
        @(negedge clk);
        while (!req_ready && k < 500) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL push_ready: req_ready=%b after %0d cycles, expected 1", req_ready, k);
        end
        req_valid = 1'b1;
        req_n = n;
        req_address = a;
        @(posedge clk);
        #1 req_valid = 1'b0;
        push_cyc = cyc;
    endtask

    task automatic wait_idle(input string tag, input int lim);
        int k = 0;
        @(negedge clk);
        while (busy && k < lim) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_idle: busy=%b after %0d cycles, expected 0", tag, busy, k);
        end
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({req_ready, cache_valid, print_pulse, busy, timeout_err} !== 5'b10000) begin
            errors++;
            $display("FAIL reset_flags: ready/valid/print/busy/err=%b expected 10000",
                     {req_ready, cache_valid, print_pulse, busy, timeout_err});
        end
        checks++;
        if ({cache_n, cache_address, issued_cnt, timeout_cnt, bad_cmd_cnt} !== '0) begin
            errors++;
            $display("FAIL reset_values: n=%h addr=%h iss=%0d to=%0d bad=%0d expected all 0",
                     cache_n, cache_address, issued_cnt, timeout_cnt, bad_cmd_cnt);
        end
        @(negedge clk);
        rstb = 1'b1;
        clear_log();
    endtask

    task automatic test_single();
        done_delay = 3;
        push(4'd0, 32'h1000_0040);
        @(negedge clk);
        checks++;
        if (cache_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_early: cache_valid=%b expected 0", cache_valid);
        end
        @(negedge clk);
        checks++;
        if ({cache_valid, cache_n, cache_address} !== {1'b1, 4'd0, 32'h1000_0040}) begin
            errors++;
            $display("FAIL single_strobe: valid=%b n=%h addr=%h expected 1 0 10000040",
                     cache_valid, cache_n, cache_address);
        end
        @(negedge clk);
        checks++;
        if (cache_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_pulse: cache_valid=%b expected 0", cache_valid);
        end
        wait_idle("single", 50);
        checks++;
        if (issued_cnt !== 16'd1 || timeout_cnt !== 16'd0 || timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL single_cnt: iss=%0d to=%0d err=%b expected 1 0 0", issued_cnt, timeout_cnt, timeout_err);
        end
    endtask

    task automatic test_timeout_fill();
        clear_log();
        done_delay = -1;
        for (int i = 0; i < 5; i++) push(4'(i), 32'hA000_0000 + 32'(i * 16));
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b0) begin
            errors++;
            $display("FAIL fill_ready: req_ready=%b with 4 held, expected 0", req_ready);
        end
        wait_idle("timeout", 700);
        checks++;
        if (timeout_cnt !== 16'd5 || timeout_err !== 1'b1 || issued_cnt !== 16'd6) begin
            errors++;
            $display("FAIL timeout_cnt: to=%0d err=%b iss=%0d expected 5 1 6", timeout_cnt, timeout_err, issued_cnt);
        end
        checks++;
        if (iss_n.size() != 5) begin
            errors++;
            $display("FAIL timeout_issues: %0d strobes expected 5", iss_n.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (iss_n[i] !== 4'(i) || iss_a[i] !== 32'hA000_0000 + 32'(i * 16)) begin
                    errors++;
                    $display("FAIL timeout_order%0d: n=%h addr=%h expected %h %h",
                             i, iss_n[i], iss_a[i], 4'(i), 32'hA000_0000 + 32'(i * 16));
                end
            end
            checks++;
            if (iss_c[1] - iss_c[0] != 101) begin
                errors++;
                $display("FAIL timeout_spacing: %0d cycles between strobes expected 101", iss_c[1] - iss_c[0]);
            end
        end
    endtask

    task automatic test_clear();
        clear_log();
        done_delay = 1;
        push(4'd8, 32'h0);
        push(4'd12, 32'h0);
        for (int i = 0; i < 3; i++) push(4'd0, 32'hB000_0000 + 32'(i));
        wait_idle("clear_pre", 100);
        checks++;
        if (issued_cnt !== 16'd3 || bad_cmd_cnt !== 16'd1) begin
            errors++;
            $display("FAIL clear_pre: iss=%0d bad=%0d expected 3 1", issued_cnt, bad_cmd_cnt);
        end
        clear_log();
        push(4'd8, 32'hC1EA_0000);
        wait_idle("clear", 50);
        checks++;
        if (iss_n.size() != 1 || iss_n[0] !== 4'd8 || iss_a[0] !== 32'hC1EA_0000) begin
            errors++;
            $display("FAIL clear_strobe: %0d strobes, first n=%h expected 1 strobe n=8", iss_n.size(),
                     iss_n.size() > 0 ? iss_n[0] : 4'hx);
        end
        checks++;
        if (issued_cnt !== 16'd0 || bad_cmd_cnt !== 16'd0 || timeout_cnt !== 16'd5 || timeout_err !== 1'b1) begin
            errors++;
            $display("FAIL clear_cnt: iss=%0d bad=%0d to=%0d err=%b expected 0 0 5 1",
                     issued_cnt, bad_cmd_cnt, timeout_cnt, timeout_err);
        end
    endtask

    task automatic test_local();
        int p0;
        do_reset();
        done_delay = 1;
        push(4'd9, 32'h9);
        p0 = push_cyc;
        push(4'd7, 32'h7);
        push(4'd15, 32'hF);
        push(4'd2, 32'h2222_0000);
        wait_idle("local", 50);
        checks++;
        if (prt_cnt != 1 || bad_cmd_cnt !== 16'd2 || issued_cnt !== 16'd1) begin
            errors++;
            $display("FAIL local_cnt: prints=%0d bad=%0d iss=%0d expected 1 2 1", prt_cnt, bad_cmd_cnt, issued_cnt);
        end
        checks++;
        if (iss_n.size() != 1 || iss_n[0] !== 4'd2 || iss_a[0] !== 32'h2222_0000 || iss_c[0] != p0 + 4) begin
            errors++;
            $display("FAIL local_issue: %0d strobes, first n=%h at +%0d expected 1 strobe n=2 at +4",
                     iss_n.size(), iss_n.size() > 0 ? iss_n[0] : 4'hx, iss_c.size() > 0 ? iss_c[0] - p0 : -1);
        end
    endtask

    task automatic test_done_at_limit();
        do_reset();
        done_delay = 99;
        push(4'd3, 32'h3333_0000);
        wait_idle("limit", 200);
        checks++;
        if (timeout_cnt !== 16'd0 || timeout_err !== 1'b0 || issued_cnt !== 16'd1) begin
            errors++;
            $display("FAIL limit_done: to=%0d err=%b iss=%0d expected 0 0 1", timeout_cnt, timeout_err, issued_cnt);
        end
    endtask

    task automatic test_reset_mid_wait();
        int k = 0;
        do_reset();
        push(4'd1, 32'h1);
        push(4'd2, 32'h2);
        push(4'd3, 32'h3);
        push(4'd4, 32'h4);
        @(negedge clk);
        while (!(cache_valid && cache_n == 4'd2) && k < 300) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (cache_valid !== 1'b1 || cache_n !== 4'd2 || timeout_cnt !== 16'd1) begin
            errors++;
            $display("FAIL midwait_setup: valid=%b n=%h to=%0d expected 1 2 1", cache_valid, cache_n, timeout_cnt);
        end
        rstb = 1'b0;
        #1;
        checks++;
        if ({cache_valid, req_ready, busy, timeout_err} !== 4'b0100) begin
            errors++;
            $display("FAIL midwait_flags: valid/ready/busy/err=%b expected 0100", {cache_valid, req_ready, busy, timeout_err});
        end
        checks++;
        if ({issued_cnt, timeout_cnt, bad_cmd_cnt, cache_n, cache_address} !== '0) begin
            errors++;
            $display("FAIL midwait_values: iss=%0d to=%0d bad=%0d n=%h addr=%h expected all 0",
                     issued_cnt, timeout_cnt, bad_cmd_cnt, cache_n, cache_address);
        end
        @(negedge clk);
        @(negedge clk);
        clear_log();
        rstb = 1'b1;
        repeat (20) @(negedge clk);
        checks++;
        if (iss_n.size() != 0 || busy !== 1'b0 || issued_cnt !== 16'd0) begin
            errors++;
            $display("FAIL midwait_stale: strobes=%0d busy=%b iss=%0d expected 0 0 0", iss_n.size(), busy, issued_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_timeout_fill();
        test_clear();
        test_local();
        test_done_at_limit();
        test_reset_mid_wait();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
